// File: rtl/y86_seq_controller_pkg.sv
// Shared types and constants for the sequential Y86 controller.
// Defines the status codes, the FSM state encoding and the stage-enable decode.
package y86_pkg;

  localparam int unsigned STAT_W    = 3;
  localparam int unsigned STAGE_CNT = 6;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;
  localparam int unsigned STG_P = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WRBACK  = 3'd5,
    S_PCUPD   = 3'd6,
    S_HALTED  = 3'd7
  } state_t;

  // One-hot stage enable for a given state; all-zero outside the stage states.
  function automatic logic [STAGE_CNT-1:0] stage_onehot(input state_t s);
    logic [STAGE_CNT-1:0] v;
    v = '0;
    case (s)
      S_FETCH:   v[STG_F] = 1'b1;
      S_DECODE:  v[STG_D] = 1'b1;
      S_EXECUTE: v[STG_E] = 1'b1;
      S_MEMORY:  v[STG_M] = 1'b1;
      S_WRBACK:  v[STG_W] = 1'b1;
      S_PCUPD:   v[STG_P] = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_stage_state(input state_t s);
    return |stage_onehot(s);
  endfunction

endpackage

// File: rtl/y86_seq_controller_if.sv
// Control/status bundle between the sequencer (master) and the core datapath (slave).
interface y86_seq_controller_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) ();

  logic                            run;
  logic                            step;
  logic                            bp_en;
  logic [ADDR_W-1:0]               bp_addr;
  logic [ADDR_W-1:0]               updated_pc;
  logic                            hlt;
  logic                            imem_error;
  logic                            instr_valid;
  logic                            dmem_error;

  logic [ADDR_W-1:0]               pc;
  logic [y86_pkg::STAGE_CNT-1:0]   stage_en;
  logic [y86_pkg::STAT_W-1:0]      stat;
  logic                            busy;
  logic                            bp_hit;
  logic [CNT_W-1:0]                cycle_cnt;
  logic [CNT_W-1:0]                retired_cnt;

  modport master (
    input  run, step, bp_en, bp_addr, updated_pc,
    input  hlt, imem_error, instr_valid, dmem_error,
    output pc, stage_en, stat, busy, bp_hit, cycle_cnt, retired_cnt
  );

  modport slave (
    output run, step, bp_en, bp_addr, updated_pc,
    output hlt, imem_error, instr_valid, dmem_error,
    input  pc, stage_en, stat, busy, bp_hit, cycle_cnt, retired_cnt
  );

endinterface

// File: rtl/y86_seq_controller_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module y86_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the sequential Y86 core: owns the PC, steps the six
// stages one per clock, latches status, and supports run/step/breakpoint control.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       CNT_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  y86_seq_controller_if.master bus
);

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_pc;
  logic [STAGE_CNT-1:0]   r_stage_en;
  logic [STAT_W-1:0]      r_stat;
  logic                   r_busy;
  logic                   r_bp_hit;
  logic                   r_step_lat;

  state_t                 w_state_nxt;
  logic [ADDR_W-1:0]      w_pc_nxt;
  logic [STAT_W-1:0]      w_stat_nxt;
  logic                   w_bp_hit_nxt;
  logic                   w_step_lat_nxt;
  logic                   w_retire;
  logic                   w_cycle_inc;
  logic [CNT_W-1:0]       w_cycle_cnt;
  logic [CNT_W-1:0]       w_retired_cnt;

  // Next-state and next-output evaluation; status inputs only matter in their own stage.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_stat_nxt     = r_stat;
    w_bp_hit_nxt   = r_bp_hit;
    w_step_lat_nxt = r_step_lat;
    w_retire       = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Leaving IDLE always starts the first instruction, which is exempt from the breakpoint.
        if (bus.run || bus.step) begin
          w_state_nxt    = S_FETCH;
          w_step_lat_nxt = !bus.run;
          w_bp_hit_nxt   = 1'b0;
        end
      end
      S_FETCH: begin
        if (bus.imem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALTED;
        end else if (!bus.instr_valid) begin
          w_stat_nxt  = STAT_INS;
          w_state_nxt = S_HALTED;
        end else if (bus.hlt) begin
          w_stat_nxt  = STAT_HLT;
          w_state_nxt = S_HALTED;
          w_retire    = 1'b1;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (bus.dmem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_WRBACK;
        end
      end
      S_WRBACK: w_state_nxt = S_PCUPD;
      S_PCUPD: begin
        w_pc_nxt = bus.updated_pc;
        w_retire = 1'b1;
        if (bus.run && !r_step_lat) begin
          if (bus.bp_en && (bus.updated_pc == bus.bp_addr)) begin
            w_state_nxt  = S_IDLE;
            w_bp_hit_nxt = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cycle_inc = is_stage_state(r_state);

  // State and registered outputs; stage_en/busy are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_stage_en <= '0;
      r_stat     <= STAT_AOK;
      r_busy     <= 1'b0;
      r_bp_hit   <= 1'b0;
      r_step_lat <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_stage_en <= stage_onehot(w_state_nxt);
      r_stat     <= w_stat_nxt;
      r_busy     <= is_stage_state(w_state_nxt);
      r_bp_hit   <= w_bp_hit_nxt;
      r_step_lat <= w_step_lat_nxt;
    end
  end

  y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_cycle_inc),
    .count (w_cycle_cnt)
  );

  y86_sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_retire),
    .count (w_retired_cnt)
  );

  assign bus.pc          = r_pc;
  assign bus.stage_en    = r_stage_en;
  assign bus.stat        = r_stat;
  assign bus.busy        = r_busy;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.cycle_cnt   = w_cycle_cnt;
  assign bus.retired_cnt = w_retired_cnt;

endmodule
